// File: rtl/mux_canais_pkg.sv
// Shared definitions for the N-channel pipelined selector: output-register
// state encoding and the default datapath word width.
package mux_canais_pkg;

  localparam int LARGURA_PADRAO = 64;

  typedef enum logic {
    ESTADO_VAZIO = 1'b0,
    ESTADO_CHEIO = 1'b1
  } estado_t;

endpackage

// File: rtl/mux_canais_if.sv
// Handshake bundle of mux_canais: per-channel producer signals plus the
// registered output towards the consumer.
interface mux_canais_if
  import mux_canais_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int CANAIS  = 4
);
  localparam int SEL_W = $clog2(CANAIS);

  logic [CANAIS*LARGURA-1:0] entradas;
  logic [CANAIS-1:0]         validos;
  logic [CANAIS-1:0]         prontos;
  logic [SEL_W-1:0]          seletor;
  logic                      modo_rr;
  logic [LARGURA-1:0]        saida;
  logic                      saida_valida;
  logic                      saida_pronta;
  logic [SEL_W-1:0]          canal_out;

  modport master (
    output entradas, validos, seletor, modo_rr, saida_pronta,
    input  prontos, saida, saida_valida, canal_out
  );

  modport slave (
    input  entradas, validos, seletor, modo_rr, saida_pronta,
    output prontos, saida, saida_valida, canal_out
  );

endinterface

// File: rtl/mux_canais_arbitro_rr.sv
// Round-robin grant search: first valid channel after ptr, wrapping modulo
// CANAIS. Used by mux_canais only when MUX_ROUND_ROBIN_EN is defined.
module arbitro_rr #(
  parameter int CANAIS = 4,
  parameter int SEL_W  = $clog2(CANAIS)
) (
  input  logic [CANAIS-1:0] validos,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_ok
);

  int melhor;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves it unassigned (no latch).
    grant    = '0;
    grant_ok = 1'b0;
    melhor   = CANAIS;
    for (int i = 0; i < CANAIS; i++) begin
      // Distance 0 is the channel right after ptr.
      if (validos[i] && ((i + CANAIS - 1 - int'(ptr)) % CANAIS) < melhor) begin
        melhor   = (i + CANAIS - 1 - int'(ptr)) % CANAIS;
        grant    = SEL_W'(i);
        grant_ok = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_canais.sv
// N-channel selector with one registered output stage and valid/ready on every
// channel. Optional round-robin arbitration under MUX_ROUND_ROBIN_EN.
module mux_canais
  import mux_canais_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int CANAIS  = 4
) (
  input logic         clk,
  input logic         rst_n,
  mux_canais_if.slave bus
);

  localparam int SEL_W = $clog2(CANAIS);

  estado_t            estado;
  logic [LARGURA-1:0] saida_q;
  logic [SEL_W-1:0]   canal_q;
  logic               pode_aceitar;
  logic               fixo_ok;
  logic [SEL_W-1:0]   g;
  logic               g_ok;
  logic               captura;
  logic [LARGURA-1:0] dado;

  assign pode_aceitar = (estado == ESTADO_VAZIO) || bus.saida_pronta;
  assign fixo_ok      = int'(bus.seletor) < CANAIS;

`ifdef MUX_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] g_rr;
  logic             g_rr_ok;

  arbitro_rr #(.CANAIS(CANAIS), .SEL_W(SEL_W)) u_arbitro_rr (
    .validos  (bus.validos),
    .ptr      (ptr),
    .grant    (g_rr),
    .grant_ok (g_rr_ok)
  );

  always_comb begin
    g    = bus.seletor;
    g_ok = fixo_ok;
    if (bus.modo_rr) begin
      g    = g_rr;
      g_ok = g_rr_ok;
    end
  end

  // The pointer only moves on an actual capture; stalls and idle cycles hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= SEL_W'(CANAIS - 1);
    else if (captura) ptr <= g;
  end
`else
  logic unused_modo_rr;
  assign unused_modo_rr = bus.modo_rr;
  assign g              = bus.seletor;
  assign g_ok           = fixo_ok;
`endif

  // Only the granted channel sees ready; everyone else waits with ready low.
  always_comb begin
    bus.prontos = '0;
    captura     = 1'b0;
    dado        = '0;
    for (int i = 0; i < CANAIS; i++) begin
      if (g_ok && g == SEL_W'(i)) begin
        bus.prontos[i] = pode_aceitar;
        captura        = pode_aceitar && bus.validos[i];
        dado           = bus.entradas[i*LARGURA +: LARGURA];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      estado  <= ESTADO_VAZIO;
      saida_q <= '0;
      canal_q <= '0;
    end else begin
      case (estado)
        ESTADO_VAZIO: begin
          if (captura) begin
            estado  <= ESTADO_CHEIO;
            saida_q <= dado;
            canal_q <= g;
          end
        end
        ESTADO_CHEIO: begin
          if (captura) begin
            saida_q <= dado;
            canal_q <= g;
          end else if (bus.saida_pronta) begin
            estado <= ESTADO_VAZIO;
          end
        end
        default: estado <= ESTADO_VAZIO;
      endcase
    end
  end

  assign bus.saida        = saida_q;
  assign bus.canal_out    = canal_q;
  assign bus.saida_valida = (estado == ESTADO_CHEIO);

endmodule

// File: tb/tb_mux_canais.sv
// Self-checking bench for mux_canais: table-driven fixed-select vectors on a
// 4-channel instance, plus reset, out-of-range (3 channels) and round-robin sequences.
module tb_mux_canais;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mux_canais_if #(.LARGURA(64), .CANAIS(4)) bus4 ();
  mux_canais_if #(.LARGURA(64), .CANAIS(3)) bus3 ();

  mux_canais #(.LARGURA(64), .CANAIS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  mux_canais #(.LARGURA(64), .CANAIS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  typedef struct {
    logic [3:0] validos;
    logic [1:0] seletor;
    logic       pronta;
    int         tag;
    logic [3:0] exp_prontos;
    logic       exp_valida;
    int         exp_tag;
    int         exp_canal;
  } vec_t;

  vec_t vetores [12];

  function automatic logic [63:0] palavra(input int tag, input int canal);
    return {32'hDEAD_BEEF, 16'(tag), 16'(canal)};
  endfunction

  task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    n_checks++;
    if (atual === esperado) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nome, atual, esperado, $time);
  endtask

  task automatic carrega4(input int tag);
    for (int i = 0; i < 4; i++) bus4.entradas[i*64 +: 64] = palavra(tag, i);
  endtask

  task automatic carrega3(input int tag);
    for (int i = 0; i < 3; i++) bus3.entradas[i*64 +: 64] = palavra(tag, i);
  endtask

  task automatic aplica(input vec_t v, input int idx);
    string s;
    @(negedge clk);
    bus4.validos      = v.validos;
    bus4.seletor      = v.seletor;
    bus4.saida_pronta = v.pronta;
    bus4.modo_rr      = 1'b0;
    carrega4(v.tag);
    #1;
    s = $sformatf("v%0d prontos", idx);
    check(s, 64'(bus4.prontos), 64'(v.exp_prontos));
    @(posedge clk);
    #1;
    s = $sformatf("v%0d saida_valida", idx);
    check(s, 64'(bus4.saida_valida), 64'(v.exp_valida));
    s = $sformatf("v%0d saida", idx);
    check(s, bus4.saida, palavra(v.exp_tag, v.exp_canal));
    s = $sformatf("v%0d canal_out", idx);
    check(s, 64'(bus4.canal_out), 64'(v.exp_canal));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // validos, sel, pronta, tag | prontos, valida, exp_tag, exp_canal
    vetores[0]  = '{4'b0100, 2'd2, 1'b1,  0, 4'b0100, 1'b1,  0, 2};
    vetores[1]  = '{4'b0100, 2'd2, 1'b1,  1, 4'b0100, 1'b1,  1, 2};
    vetores[2]  = '{4'b0100, 2'd2, 1'b1,  2, 4'b0100, 1'b1,  2, 2};
    vetores[3]  = '{4'b0010, 2'd1, 1'b0,  3, 4'b0000, 1'b1,  2, 2};
    vetores[4]  = '{4'b0010, 2'd1, 1'b0,  4, 4'b0000, 1'b1,  2, 2};
    vetores[5]  = '{4'b0010, 2'd1, 1'b0,  5, 4'b0000, 1'b1,  2, 2};
    vetores[6]  = '{4'b0010, 2'd1, 1'b1,  6, 4'b0010, 1'b1,  6, 1};
    vetores[7]  = '{4'b0000, 2'd1, 1'b1,  7, 4'b0010, 1'b0,  6, 1};
    vetores[8]  = '{4'b0000, 2'd3, 1'b0,  8, 4'b1000, 1'b0,  6, 1};
    vetores[9]  = '{4'b1111, 2'd0, 1'b0,  9, 4'b0001, 1'b1,  9, 0};
    vetores[10] = '{4'b1111, 2'd3, 1'b0, 10, 4'b0000, 1'b1,  9, 0};
    vetores[11] = '{4'b1111, 2'd3, 1'b1, 11, 4'b1000, 1'b1, 11, 3};

    bus4.validos = '0; bus4.seletor = '0; bus4.saida_pronta = 1'b0; bus4.modo_rr = 1'b0;
    bus3.validos = '0; bus3.seletor = '0; bus3.saida_pronta = 1'b0; bus3.modo_rr = 1'b0;
    carrega4(0);
    carrega3(0);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset saida", bus4.saida, 64'd0);
    check("reset saida_valida", 64'(bus4.saida_valida), 64'd0);
    check("reset canal_out", 64'(bus4.canal_out), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) aplica(vetores[i], i);

    // Asynchronous reset during a stall discards the held word immediately
    @(negedge clk);
    bus4.saida_pronta = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset saida", bus4.saida, 64'd0);
    check("midreset saida_valida", 64'(bus4.saida_valida), 64'd0);
    check("midreset canal_out", 64'(bus4.canal_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus4.validos = 4'b0100; bus4.seletor = 2'd2; bus4.saida_pronta = 1'b1;
    carrega4(32);
    #1 check("postreset prontos", 64'(bus4.prontos), 64'(4'b0100));
    @(posedge clk); #1;
    check("postreset saida_valida", 64'(bus4.saida_valida), 64'd1);
    check("postreset saida", bus4.saida, palavra(32, 2));
    check("postreset canal_out", 64'(bus4.canal_out), 64'd2);
    @(negedge clk);
    bus4.validos = '0;

    // Out-of-range selector on the 3-channel instance
    bus3.validos = 3'b111; bus3.seletor = 2'd0; bus3.saida_pronta = 1'b1;
    carrega3(48);
    @(posedge clk); #1;
    check("oor load valida", 64'(bus3.saida_valida), 64'd1);
    check("oor load saida", bus3.saida, palavra(48, 0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus3.seletor = 2'd3;
      carrega3(49 + k);
      #1 check("oor prontos", 64'(bus3.prontos), 64'd0);
      @(posedge clk); #1;
      check("oor saida_valida", 64'(bus3.saida_valida), 64'd0);
      check("oor saida held", bus3.saida, palavra(48, 0));
      check("oor canal_out held", 64'(bus3.canal_out), 64'd0);
    end

`ifdef MUX_ROUND_ROBIN_EN
    begin
      int seq [8] = '{0, 1, 3, -1, -1, 0, 1, 3};
      int ultimo;
      int ultimo_tag;
      ultimo = 0;
      ultimo_tag = 0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus4.modo_rr = 1'b1;
      bus4.validos = 4'b1011;
      bus4.seletor = 2'd2;
      for (int k = 0; k < 8; k++) begin
        if (k != 0) @(negedge clk);
        bus4.saida_pronta = (seq[k] >= 0);
        carrega4(64 + k);
        #1;
        if (seq[k] >= 0) check("rr prontos", 64'(bus4.prontos), 64'(1) << seq[k]);
        else             check("rr stall prontos", 64'(bus4.prontos), 64'd0);
        @(posedge clk); #1;
        if (seq[k] >= 0) begin
          ultimo = seq[k];
          ultimo_tag = 64 + k;
        end
        check("rr canal_out", 64'(bus4.canal_out), 64'(ultimo));
        check("rr saida", bus4.saida, palavra(ultimo_tag, ultimo));
        check("rr saida_valida", 64'(bus4.saida_valida), 64'd1);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
